// File: rtl/vga_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rx_monitor
//  Description : Recovers pixel position from an incoming VGA stream, measures
//                line/frame timing, locks after one verified frame and
//                captures the colour of one probed pixel per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_rx_monitor #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_SYNC_START = 656,
    parameter int V_SYNC_START = 490,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active,
    output logic        locked,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic [11:0] probe_rgb,
    output logic        probe_valid,
    output logic [7:0]  frame_cnt,
    output logic        err
);

    localparam logic [9:0] c_H_TOTAL  = 10'(H_TOTAL);
    localparam logic [9:0] c_V_TOTAL  = 10'(V_TOTAL);
    localparam logic [9:0] c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_SYNC   = 10'(H_SYNC_START);
    localparam logic [9:0] c_V_SYNC   = 10'(V_SYNC_START);
    localparam logic [9:0] c_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0] c_PCNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_s_hsync;
    logic        r_s_vsync;
    logic [11:0] r_s_rgb;
    logic [9:0]  r_hpos;
    logic [9:0]  r_vpos;
    logic [9:0]  r_pcnt;
    logic [9:0]  r_lcnt;
    logic        r_bad;
    logic        r_first;

    logic        w_hfall;
    logic        w_vfall;
    logic        w_hwrap;
    logic [9:0]  w_pcnt_inc;
    logic [9:0]  w_lcnt_now;
    logic        w_period_ok;
    logic        w_lines_ok;
    logic        w_timeout;
    logic        w_bad_now;

    // Sync falling edges are taken against the previous sampled level so they
    // line up with the tick that brings the first low pixel into the sample stage.
    assign w_hfall     = p_tick && r_s_hsync && !hsync;
    assign w_vfall     = p_tick && r_s_vsync && !vsync;
    assign w_hwrap     = !w_hfall && (r_hpos == c_H_LAST);
    assign w_pcnt_inc  = r_pcnt + 10'd1;
    assign w_lcnt_now  = w_hfall ? (r_lcnt + 10'd1) : r_lcnt;
    assign w_period_ok = (w_pcnt_inc == c_H_TOTAL);
    assign w_lines_ok  = (w_lcnt_now == c_V_TOTAL);
    // Timeout fires on the tick that takes the period counter to its ceiling.
    assign w_timeout   = p_tick && !w_hfall && (r_pcnt >= (c_PCNT_MAX - 10'd1));
    // The first hfall after entering TRACK measures from an unknown origin.
    assign w_bad_now   = r_bad || (w_hfall && !r_first && !w_period_ok);

    assign x      = r_hpos;
    assign y      = r_vpos;
    assign locked = (r_state == ST_LOCKED);
    assign active = locked && (r_hpos < c_H_ACTIVE) && (r_vpos < c_V_ACTIVE);

    // Sample stage, position recovery and period/line measurement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_hsync <= 1'b1;
            r_s_vsync <= 1'b1;
            r_s_rgb   <= '0;
            r_hpos    <= '0;
            r_vpos    <= '0;
            r_pcnt    <= '0;
            r_lcnt    <= '0;
            h_total   <= '0;
            v_total   <= '0;
        end else if (p_tick) begin
            r_s_hsync <= hsync;
            r_s_vsync <= vsync;
            r_s_rgb   <= rgb;

            if (w_hfall) begin
                r_hpos <= c_H_SYNC;
            end else if (r_hpos == c_H_LAST) begin
                r_hpos <= '0;
            end else begin
                r_hpos <= r_hpos + 10'd1;
            end

            if (w_vfall) begin
                r_vpos <= c_V_SYNC;
            end else if (w_hwrap) begin
                r_vpos <= (r_vpos == c_V_LAST) ? 10'd0 : (r_vpos + 10'd1);
            end

            if (w_hfall) begin
                h_total <= w_pcnt_inc;
                r_pcnt  <= '0;
            end else if (r_pcnt != c_PCNT_MAX) begin
                r_pcnt  <= w_pcnt_inc;
            end

            if (w_vfall) begin
                v_total <= w_lcnt_now;
                r_lcnt  <= '0;
            end else begin
                r_lcnt  <= w_lcnt_now;
            end
        end
    end

    // Lock state machine with frame counter and lock-loss pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_SEARCH;
            r_bad     <= 1'b0;
            r_first   <= 1'b0;
            frame_cnt <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (w_timeout) begin
                if (r_state == ST_LOCKED) begin
                    err <= 1'b1;
                end
                r_state <= ST_SEARCH;
            end else if (p_tick) begin
                case (r_state)
                    ST_SEARCH: begin
                        if (w_vfall) begin
                            r_state <= ST_TRACK;
                            r_bad   <= 1'b0;
                            r_first <= 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (w_hfall) begin
                            r_first <= 1'b0;
                        end
                        if (w_vfall) begin
                            if (!w_bad_now && w_lines_ok) begin
                                r_state <= ST_LOCKED;
                            end
                            r_bad <= 1'b0;
                        end else begin
                            r_bad <= w_bad_now;
                        end
                    end
                    ST_LOCKED: begin
                        if ((w_hfall && !w_period_ok) || (w_vfall && !w_lines_ok)) begin
                            r_state <= ST_SEARCH;
                            err     <= 1'b1;
                        end else if (w_vfall) begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                    end
                endcase
            end
        end
    end

    // Probe capture uses the registered position/colour pair, which always
    // describe the same pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            probe_valid <= 1'b0;
            if (p_tick && active && (r_hpos == probe_x) && (r_vpos == probe_y)) begin
                probe_rgb   <= r_s_rgb;
                probe_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_rx_monitor
//  Description : Self-checking bench for vga_rx_monitor using a reduced video
//                timing (64x40 total, 48x30 visible) and a probe scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rx_monitor;

    localparam int HT = 64;
    localparam int VT = 40;
    localparam int HS = 52;
    localparam int HW = 8;
    localparam int VS = 32;
    localparam int VW = 2;
    localparam int HA = 48;
    localparam int VA = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic [9:0]  probe_x;
    logic [9:0]  probe_y;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active;
    logic        locked;
    logic [9:0]  h_total;
    logic [9:0]  v_total;
    logic [11:0] probe_rgb;
    logic        probe_valid;
    logic [7:0]  frame_cnt;
    logic        err;

    int total = 0;
    int bad   = 0;
    int bx = 0, by = 0, lx = 0, ly = 0;
    int short_y = -1;
    bit hold_h = 1'b0;
    bit expect_lock = 1'b0;
    int err_cnt = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];

    vga_rx_monitor #(
        .H_TOTAL      (HT),
        .V_TOTAL      (VT),
        .H_SYNC_START (HS),
        .V_SYNC_START (VS),
        .H_ACTIVE     (HA),
        .V_ACTIVE     (VA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (p_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .probe_x     (probe_x),
        .probe_y     (probe_y),
        .x           (x),
        .y           (y),
        .active      (active),
        .locked      (locked),
        .h_total     (h_total),
        .v_total     (v_total),
        .probe_rgb   (probe_rgb),
        .probe_valid (probe_valid),
        .frame_cnt   (frame_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Collect probe captures and lock-loss pulses.
    always @(negedge clk) begin
        if (probe_valid) obs_q.push_back(probe_rgb);
        if (err) err_cnt++;
    end

    // Drive one pixel (p_tick every other clock) and advance the source raster.
    task automatic pix();
        logic [11:0] c;
        @(negedge clk);
        c = {bx[3:0], by[3:0], 4'h5};
        hsync  = hold_h ? 1'b1 : !(bx >= HS && bx < HS + HW);
        vsync  = !(by >= VS && by < VS + VW);
        rgb    = c;
        p_tick = 1'b1;
        if (expect_lock && bx == int'(probe_x) && by == int'(probe_y) && bx < HA && by < VA)
            exp_q.push_back(c);
        lx = bx;
        ly = by;
        @(negedge clk);
        p_tick = 1'b0;
        if (bx == HT - 1 || (by == short_y && bx == HT - 2)) begin
            bx = 0;
            by = (by == VT - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) pix();
    endtask

    task automatic run_to(input int tx, input int ty);
        int n = 0;
        do begin
            pix();
            n++;
        end while (!(lx == tx && ly == ty) && n < 3 * HT * VT);
        if (n >= 3 * HT * VT) begin
            total++; bad++;
            $display("FAIL run_to(%0d,%0d): position never reached", tx, ty);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0;
        probe_x = 10'h3FF; probe_y = 10'h3FF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({x, y} !== 20'd0) begin bad++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x, y); end
        total++; if ({h_total, v_total} !== 20'd0) begin bad++; $display("FAIL reset_totals: got %0d %0d expected 0 0", h_total, v_total); end
        total++; if ({active, locked, probe_valid, err} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b expected 0000", {active, locked, probe_valid, err}); end
        total++; if (probe_rgb !== 12'h000) begin bad++; $display("FAIL reset_probe_rgb: got %h expected 000", probe_rgb); end
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    endtask

    task automatic test_lock();
        run_to(0, VS);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_vfall1: locked=%b expected 0", locked); end
        total++; if (v_total !== 10'd32) begin bad++; $display("FAIL vtotal_vfall1: got %0d expected 32", v_total); end
        total++; if (h_total !== 10'd64) begin bad++; $display("FAIL htotal_vfall1: got %0d expected 64", h_total); end
        run_to(0, VS);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_vfall2: locked=%b expected 1", locked); end
        total++; if (v_total !== 10'd40) begin bad++; $display("FAIL vtotal_vfall2: got %0d expected 40", v_total); end
        total++; if ({x, y} !== {10'd0, 10'd32}) begin bad++; $display("FAIL pos_vfall2: got (%0d,%0d) expected (0,32)", x, y); end
        expect_lock = 1'b1;
        run_to(5, 5);
        total++; if ({x, y, active} !== {10'd5, 10'd5, 1'b1}) begin bad++; $display("FAIL align_5_5: got (%0d,%0d) active=%b expected (5,5) 1", x, y, active); end
        run_to(47, 29);
        total++; if (active !== 1'b1) begin bad++; $display("FAIL active_47_29: got %b expected 1", active); end
        run_to(48, 29);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL active_48_29: got %b expected 0", active); end
        run_to(5, 30);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL active_5_30: got %b expected 0", active); end
        run_to(0, VS);
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL frame_cnt_vfall3: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_probe();
        int ob, eb;
        probe_x = 10'd20; probe_y = 10'd18;
        ob = obs_q.size(); eb = exp_q.size();
        run_to(0, VS);
        run_to(0, VS);
        total++;
        if (obs_q.size() - ob !== exp_q.size() - eb) begin
            bad++; $display("FAIL probe_count: got %0d captures expected %0d", obs_q.size() - ob, exp_q.size() - eb);
        end else begin
            for (int i = 0; i < exp_q.size() - eb; i++) begin
                total++;
                if (obs_q[ob + i] !== exp_q[eb + i]) begin bad++; $display("FAIL probe_sb[%0d]: got %h expected %h", i, obs_q[ob + i], exp_q[eb + i]); end
            end
        end
        total++; if (obs_q.size() <= ob || obs_q[ob] !== 12'h425) begin bad++; $display("FAIL probe_rgb_20_18: got %h expected 425", probe_rgb); end
        total++; if (frame_cnt !== 8'd3) begin bad++; $display("FAIL frame_cnt_probe: got %0d expected 3", frame_cnt); end
        probe_x = 10'd48; probe_y = 10'd29;
        ob = obs_q.size();
        run_to(0, VS);
        total++; if (obs_q.size() !== ob) begin bad++; $display("FAIL probe_outside: got %0d captures expected 0", obs_q.size() - ob); end
        probe_x = 10'd47; probe_y = 10'd29;
        ob = obs_q.size(); eb = exp_q.size();
        run_to(0, VS);
        total++;
        if (obs_q.size() - ob !== 1 || exp_q.size() - eb !== 1) begin
            bad++; $display("FAIL probe_corner_count: got %0d captures expected 1", obs_q.size() - ob);
        end else if (obs_q[ob] !== exp_q[eb] || obs_q[ob] !== 12'hFD5) begin
            bad++; $display("FAIL probe_corner: got %h expected fd5", obs_q[ob]);
        end
    endtask

    task automatic test_short_line();
        int base = err_cnt;
        short_y = 5;
        run_to(52, 6);
        short_y = -1;
        expect_lock = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL short_err: got %b expected 1", err); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_locked: got %b expected 0", locked); end
        total++; if (h_total !== 10'd63) begin bad++; $display("FAIL short_htotal: got %0d expected 63", h_total); end
        run_to(0, VS);
        total++; if ({locked, v_total} !== {1'b0, 10'd40}) begin bad++; $display("FAIL short_track: locked=%b v_total=%0d expected 0 40", locked, v_total); end
        run_to(0, VS);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL short_relock: got %b expected 1", locked); end
        total++; if (err_cnt - base !== 1) begin bad++; $display("FAIL short_err_count: got %0d expected 1", err_cnt - base); end
        expect_lock = 1'b1;
    endtask

    task automatic test_timeout();
        int base = err_cnt;
        run_to(52, 1);
        hold_h = 1'b1;
        run_n(1022);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL timeout_early: locked=%b expected 1", locked); end
        run_n(1);
        expect_lock = 1'b0;
        total++; if ({locked, err} !== 2'b01) begin bad++; $display("FAIL timeout_drop: locked=%b err=%b expected 0 1", locked, err); end
        run_to(5, 18);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL timeout_active: got %b expected 0", active); end
        hold_h = 1'b0;
        run_to(0, VS);
        run_to(0, VS);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL timeout_relock: got %b expected 1", locked); end
        total++; if (err_cnt - base !== 1) begin bad++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - base); end
        expect_lock = 1'b1;
    endtask

    task automatic test_reset_mid();
        int base = err_cnt;
        run_to(10, 12);
        #2 reset = 1'b1;
        expect_lock = 1'b0;
        #1;
        total++; if ({locked, active, x, y} !== 22'd0) begin bad++; $display("FAIL midreset_pos: locked=%b x=%0d y=%0d expected 0 0 0", locked, x, y); end
        total++; if ({frame_cnt, probe_rgb, h_total, v_total} !== 40'd0) begin bad++; $display("FAIL midreset_regs: fc=%0d prgb=%h ht=%0d vt=%0d expected zeros", frame_cnt, probe_rgb, h_total, v_total); end
        @(negedge clk);
        reset = 1'b0;
        probe_x = 10'd20; probe_y = 10'd18;
        run_to(0, VS);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midreset_vfall1: locked=%b expected 0", locked); end
        run_to(0, VS);
        total++; if ({locked, h_total, v_total} !== {1'b1, 10'd64, 10'd40}) begin bad++; $display("FAIL midreset_relock: locked=%b ht=%0d vt=%0d expected 1 64 40", locked, h_total, v_total); end
        total++; if (err_cnt - base !== 0) begin bad++; $display("FAIL midreset_err_count: got %0d expected 0", err_cnt - base); end
    endtask

    task automatic test_final();
        repeat (4) @(negedge clk);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL scoreboard_total: got %0d captures expected %0d", obs_q.size(), exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_probe();
        test_short_line();
        test_timeout();
        test_reset_mid();
        test_final();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
